instr_mem_loader: RTL and testbench

- Writer side of the 20-bit instruction memory (ram_async, 8 x 20) that the Burrito datapath fetches from.
- Accepts decoded instruction fields over a valid/ready handshake and packs them into the 20-bit instruction format.
- Writes packed words into consecutive RAM addresses from 0, using a safe setup/pulse/release sequence for the asynchronous RAM.
- Reports busy, done, full and error status to the bench or a host controller.

---
 rtl/instr_mem_loader.sv | 138 +++++++++++++
 tb/tb_instr_mem_loader.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/instr_mem_loader.sv
// instr_mem_loader
//   Writer side of the 8 x 20 asynchronous instruction RAM. Decoded
//   instruction fields arrive over a valid/ready handshake. Each accepted
//   instruction is packed into the 20-bit format and written to
//   consecutive RAM addresses, starting from 0. Every write uses a
//   setup / pulse / release sequence, so address and data stay stable
//   around the single-cycle write-enable pulse.
//
// Parameters
//   AW      RAM address width
//   DEPTH   number of instruction slots (DEPTH <= 2**AW)
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   start               begin a load session (honoured in IDLE or DONE)
//   in_valid/in_ready   field handshake
//   in_we,in_op,in_d1,
//   in_d2,in_rd         fields packed {we, op, d1, d2, rd}
//   in_last             final instruction of the session
//   ram_we,ram_addr,
//   ram_din             RAM write port (all registered)
//   count               words written in this session
//   busy, done, full,
//   err                 session status
module instr_mem_loader #(
    parameter int AW    = 3,
    parameter int DEPTH = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          in_we,
    input  logic [3:0]    in_op,
    input  logic [4:0]    in_d1,
    input  logic [4:0]    in_d2,
    input  logic [4:0]    in_rd,
    input  logic          in_last,
    output logic          ram_we,
    output logic [AW-1:0] ram_addr,
    output logic [19:0]   ram_din,
    output logic [AW:0]   count,
    output logic          busy,
    output logic          done,
    output logic          full,
    output logic          err
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_ACCEPT  = 3'd1;
    localparam logic [2:0] S_SETUP   = 3'd2;
    localparam logic [2:0] S_PULSE   = 3'd3;
    localparam logic [2:0] S_RELEASE = 3'd4;
    localparam logic [2:0] S_DONE    = 3'd5;

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [2:0] state;
    logic       last_q;

    // Status outputs decode the state register only, so no input reaches
    // them combinationally.
    assign in_ready = (state == S_ACCEPT);
    assign done     = (state == S_DONE);
    assign busy     = (state == S_ACCEPT) || (state == S_SETUP) ||
                      (state == S_PULSE)  || (state == S_RELEASE);

    // count doubles as the write pointer. It is always below DEPTH while a
    // word is being accepted, so the low AW bits are the target address.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            last_q   <= 1'b0;
            ram_we   <= 1'b0;
            ram_addr <= '0;
            ram_din  <= '0;
            count    <= '0;
            full     <= 1'b0;
            err      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state <= S_ACCEPT;
                        count <= '0;
                        full  <= 1'b0;
                        err   <= 1'b0;
                    end
                end
                S_ACCEPT: begin
                    if (in_valid) begin
                        ram_din  <= {in_we, in_op, in_d1, in_d2, in_rd};
                        ram_addr <= count[AW-1:0];
                        last_q   <= in_last;
                        state    <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    // Raise the write enable one cycle after address/data settle.
                    ram_we <= 1'b1;
                    state  <= S_PULSE;
                end
                S_PULSE: begin
                    ram_we <= 1'b0;
                    state  <= S_RELEASE;
                end
                S_RELEASE: begin
                    count <= count + 1'b1;
                    if (last_q) begin
                        state <= S_DONE;
                    end else if (count + 1'b1 == FULL_CNT) begin
                        full  <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        state <= S_ACCEPT;
                    end
                end
                S_DONE: begin
                    // If start arrives together with in_valid, start wins.
                    if (start) begin
                        state <= S_ACCEPT;
                        count <= '0;
                        full  <= 1'b0;
                        err   <= 1'b0;
                    end else if (in_valid) begin
                        err <= 1'b1;
                    end
                end
                default: begin
                    state  <= S_IDLE;
                    ram_we <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_mem_loader.sv
// tb_instr_mem_loader
//   Directed test of instr_mem_loader. It uses hand-packed instruction
//   words and models the asynchronous RAM behaviourally.
module tb_instr_mem_loader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, in_valid, in_ready;
    logic        in_we, in_last;
    logic [3:0]  in_op;
    logic [4:0]  in_d1, in_d2, in_rd;
    logic        ram_we;
    logic [2:0]  ram_addr;
    logic [19:0] ram_din;
    logic [3:0]  count;
    logic        busy, done, full, err;

    int total = 0;
    int bad   = 0;

    instr_mem_loader #(.AW(3), .DEPTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_we(in_we), .in_op(in_op), .in_d1(in_d1), .in_d2(in_d2),
        .in_rd(in_rd), .in_last(in_last),
        .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din),
        .count(count), .busy(busy), .done(done), .full(full), .err(err)
    );

    always #5 clk = ~clk;

    // RAM model plus write-pulse monitor, sampled mid-cycle.
    logic [19:0] mem [0:7];
    int  we_cnt = 0;
    int  consec = 0;
    logic prev_we = 1'b0;
    always @(negedge clk) begin
        if (ram_we === 1'b1) begin
            we_cnt = we_cnt + 1;
            mem[ram_addr] = ram_din;
            if (prev_we) consec = consec + 1;
        end
        prev_we = (ram_we === 1'b1);
    end

    // Hand-packed vectors: {we, op, d1, d2, rd}
    logic        t_we  [8];
    logic [3:0]  t_op  [8];
    logic [4:0]  t_d1  [8];
    logic [4:0]  t_d2  [8];
    logic [4:0]  t_rd  [8];
    logic [19:0] t_exp [8];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total = total + 1;
        assert (obs === exp) else begin
            bad = bad + 1;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_fields(input int i, input logic last);
        in_we   = t_we[i];
        in_op   = t_op[i];
        in_d1   = t_d1[i];
        in_d2   = t_d2[i];
        in_rd   = t_rd[i];
        in_last = last;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int base;
        t_we[0]=0; t_op[0]=4'h1; t_d1[0]=0;  t_d2[0]=0;  t_rd[0]=1;  t_exp[0]=20'h08001;
        t_we[1]=1; t_op[1]=4'h3; t_d1[1]=2;  t_d2[1]=1;  t_rd[1]=4;  t_exp[1]=20'h98824;
        t_we[2]=1; t_op[2]=4'hF; t_d1[2]=31; t_d2[2]=31; t_rd[2]=31; t_exp[2]=20'hFFFFF;
        t_we[3]=0; t_op[3]=4'h0; t_d1[3]=0;  t_d2[3]=0;  t_rd[3]=0;  t_exp[3]=20'h00000;
        t_we[4]=1; t_op[4]=4'h8; t_d1[4]=16; t_d2[4]=8;  t_rd[4]=5;  t_exp[4]=20'hC4105;
        t_we[5]=0; t_op[5]=4'h5; t_d1[5]=3;  t_d2[5]=7;  t_rd[5]=9;  t_exp[5]=20'h28CE9;
        t_we[6]=1; t_op[6]=4'h6; t_d1[6]=10; t_d2[6]=20; t_rd[6]=30; t_exp[6]=20'hB2A9E;
        t_we[7]=0; t_op[7]=4'h7; t_d1[7]=1;  t_d2[7]=1;  t_rd[7]=1;  t_exp[7]=20'h38421;
        for (int i = 0; i < 8; i++) mem[i] = '0;

        // 1. Reset
        rst_n = 1'b0; start = 0; in_valid = 0; in_last = 0;
        in_we = 0; in_op = '0; in_d1 = '0; in_d2 = '0; in_rd = '0;
        #3;
        chk("rst_we",    ram_we,   0);
        chk("rst_addr",  ram_addr, 0);
        chk("rst_din",   ram_din,  0);
        chk("rst_count", count,    0);
        chk("rst_ready", in_ready, 0);
        chk("rst_flags", {busy, done, full, err}, 0);
        #17 rst_n = 1'b1;
        tick();
        in_valid = 1;
        tick(); tick();
        chk("idle_ready", in_ready, 0);
        chk("idle_busy",  busy,     0);
        chk("idle_nowe",  we_cnt,   0);
        in_valid = 0;

        // 2. Packing, single word with last
        start = 1; tick(); start = 0;
        chk("p_ready", in_ready, 1);
        chk("p_busy",  busy,     1);
        in_we = 1; in_op = 4'h2; in_d1 = 1; in_d2 = 2; in_rd = 3; in_last = 1; in_valid = 1;
        tick(); in_valid = 0;                       // SETUP
        chk("p_addr",      ram_addr, 0);
        chk("p_din",       ram_din,  20'h90443);
        chk("p_setup_we",  ram_we,   0);
        chk("p_setup_rdy", in_ready, 0);
        tick();                                     // PULSE
        chk("p_pulse_we", ram_we, 1);
        tick();                                     // RELEASE
        chk("p_rel_we", ram_we, 0);
        tick();                                     // DONE
        chk("p_done",  done,   1);
        chk("p_count", count,  1);
        chk("p_full",  full,   0);
        chk("p_busy0", busy,   0);
        chk("p_mem0",  mem[0], 20'h90443);
        chk("p_wecnt", we_cnt, 1);

        // 3. Six words, valid held high; start+valid together in DONE
        base = we_cnt;
        set_fields(0, 1'b0);
        start = 1; in_valid = 1;
        tick();                                     // ACCEPT
        chk("s_err",   err,      0);
        chk("s_ready", in_ready, 1);
        chk("s_count", count,    0);
        for (int i = 0; i < 6; i++) begin
            set_fields(i, i == 5);
            tick();                                 // SETUP
            chk($sformatf("s_addr%0d", i), ram_addr, i);
            chk($sformatf("s_din%0d", i),  ram_din,  t_exp[i]);
            tick();                                 // PULSE
            chk($sformatf("s_we%0d", i), ram_we, 1);
            start = 0;                              // held through word 0: ignored
            tick();                                 // RELEASE
            tick();                                 // ACCEPT or DONE
        end
        in_valid = 0;
        chk("s_done",   done,          1);
        chk("s_count6", count,         6);
        chk("s_pulses", we_cnt - base, 6);
        chk("s_consec", consec,        0);
        for (int i = 0; i < 6; i++) chk($sformatf("s_mem%0d", i), mem[i], t_exp[i]);

        // 4. Fill without last
        base = we_cnt;
        start = 1; tick(); start = 0;
        in_valid = 1;
        for (int i = 0; i < 8; i++) begin
            set_fields(7 - i, 1'b0);
            tick();
            chk($sformatf("f_addr%0d", i), ram_addr, i);
            tick(); tick(); tick();
        end
        chk("f_done",   done,     1);
        chk("f_full",   full,     1);
        chk("f_count",  count,    8);
        chk("f_ready",  in_ready, 0);
        chk("f_pulses", we_cnt - base, 8);
        chk("f_mem7",   mem[7],   t_exp[0]);

        // 5. Post-done error (in_valid still high)
        tick(); tick();
        chk("e_err",    err,           1);
        chk("e_done",   done,          1);
        chk("e_nowe",   we_cnt - base, 8);
        chk("e_addr",   ram_addr,      7);
        in_valid = 0; start = 1; tick(); start = 0;
        chk("e_clr",    err,      0);
        chk("e_count0", count,    0);
        chk("e_full0",  full,     0);
        chk("e_accept", in_ready, 1);
        set_fields(5, 1'b1); in_valid = 1;
        tick(); in_valid = 0;
        chk("e_addr0", ram_addr, 0);
        chk("e_din",   ram_din,  t_exp[5]);
        tick(); tick(); tick();
        chk("e_mem0", mem[0], t_exp[5]);
        chk("e_cnt1", count,  1);

        // 6. Reset during the write pulse
        start = 1; tick(); start = 0;
        set_fields(2, 1'b0); in_valid = 1;
        tick(); in_valid = 0;                       // SETUP
        tick();                                     // PULSE
        chk("r_pulse", ram_we, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("r_we",    ram_we,   0);
        chk("r_count", count,    0);
        chk("r_state", {busy, done, in_ready}, 0);
        chk("r_din",   ram_din,  0);
        #5 rst_n = 1'b1;
        tick();
        start = 1; tick(); start = 0;
        set_fields(4, 1'b1); in_valid = 1;
        tick(); in_valid = 0;
        chk("r_addr0", ram_addr, 0);
        chk("r_din2",  ram_din,  t_exp[4]);
        tick(); tick(); tick();
        chk("r_done",  done,   1);
        chk("r_cnt",   count,  1);
        chk("r_mem0",  mem[0], t_exp[4]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
